// File: rtl/frame_deserializer.sv
// Bit-serial frame deserializer: hunts for a bit-aligned sync word, then assembles
// a fixed number of payload bytes MSB first and hands them out over a valid/ready port.
module frame_deserializer #(
    parameter logic [7:0] SYNC_WORD     = 8'hA5,
    parameter int         PAYLOAD_BYTES = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       serial_in,
    input  logic       serial_valid,
    output logic [7:0] data_out,
    output logic       data_valid,
    input  logic       data_ready,
    output logic       status,
    output logic       overrun,
    output logic [7:0] frame_count
);

    typedef enum logic {HUNT, PAYLOAD} state_t;

    localparam logic [7:0] LAST_BYTE = 8'(PAYLOAD_BYTES - 1);

    state_t     state, state_next;
    logic [7:0] window, window_next;
    logic [2:0] bit_cnt, bit_cnt_next;
    logic [7:0] byte_cnt, byte_cnt_next;
    logic [6:0] shift, shift_next;
    logic [7:0] data_out_next;
    logic       data_valid_next;
    logic       overrun_next;
    logic [7:0] frame_count_next;
    logic [7:0] window_shifted;
    logic [7:0] byte_assembled;
    logic       handshake;

    assign status = (state == PAYLOAD);

    always_comb begin
        state_next       = state;
        window_next      = window;
        bit_cnt_next     = bit_cnt;
        byte_cnt_next    = byte_cnt;
        shift_next       = shift;
        data_out_next    = data_out;
        data_valid_next  = data_valid;
        overrun_next     = overrun;
        frame_count_next = frame_count;
        handshake        = data_valid && data_ready;
        window_shifted   = {window[6:0], serial_in};
        byte_assembled   = {shift, serial_in};

        if (handshake) begin
            data_valid_next = 1'b0;
        end

        case (state)
            HUNT: begin
                if (serial_valid) begin
                    window_next = window_shifted;
                    if (window_shifted == SYNC_WORD) begin
                        state_next    = PAYLOAD;
                        bit_cnt_next  = 3'd0;
                        byte_cnt_next = 8'd0;
                    end
                end
            end
            PAYLOAD: begin
                if (serial_valid) begin
                    shift_next   = byte_assembled[6:0];
                    bit_cnt_next = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        // A byte finishing while the previous one is still held is dropped,
                        // but it still counts toward the frame length.
                        if (!data_valid || handshake) begin
                            data_out_next   = byte_assembled;
                            data_valid_next = 1'b1;
                        end else begin
                            overrun_next = 1'b1;
                        end
                        if (byte_cnt == LAST_BYTE) begin
                            state_next       = HUNT;
                            window_next      = 8'd0;
                            byte_cnt_next    = 8'd0;
                            frame_count_next = frame_count + 8'd1;
                        end else begin
                            byte_cnt_next = byte_cnt + 8'd1;
                        end
                    end
                end
            end
            default: state_next = HUNT;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= HUNT;
            window      <= 8'd0;
            bit_cnt     <= 3'd0;
            byte_cnt    <= 8'd0;
            shift       <= 7'd0;
            data_out    <= 8'd0;
            data_valid  <= 1'b0;
            overrun     <= 1'b0;
            frame_count <= 8'd0;
        end else begin
            state       <= state_next;
            window      <= window_next;
            bit_cnt     <= bit_cnt_next;
            byte_cnt    <= byte_cnt_next;
            shift       <= shift_next;
            data_out    <= data_out_next;
            data_valid  <= data_valid_next;
            overrun     <= overrun_next;
            frame_count <= frame_count_next;
        end
    end

endmodule

// File: tb/tb_frame_deserializer.sv
// Directed testbench for frame_deserializer: sync hunting, payload assembly,
// backpressure/overrun, reset mid-frame and frame counter wrap.
module tb_frame_deserializer;

    logic       clock = 1'b0;
    logic       reset;
    logic       serial_in;
    logic       serial_valid;
    logic [7:0] data_out;
    logic       data_valid;
    logic       data_ready;
    logic       status;
    logic       overrun;
    logic [7:0] frame_count;

    int checkCount = 0;
    int passCount  = 0;

    frame_deserializer #(.SYNC_WORD(8'hA5), .PAYLOAD_BYTES(4)) dut (
        .clock       (clock),
        .reset       (reset),
        .serial_in   (serial_in),
        .serial_valid(serial_valid),
        .data_out    (data_out),
        .data_valid  (data_valid),
        .data_ready  (data_ready),
        .status      (status),
        .overrun     (overrun),
        .frame_count (frame_count)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        checkCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Sends the low nbits of value MSB first; gap inserts an idle (serial_valid=0) cycle after each bit.
    task automatic applyStimulus(input logic [7:0] value, input int nbits, input bit gap);
        for (int i = nbits - 1; i >= 0; i--) begin
            serial_in    = value[i];
            serial_valid = 1'b1;
            @(posedge clock);
            #1;
            serial_valid = 1'b0;
            if (gap) begin
                @(posedge clock);
                #1;
            end
        end
    endtask

    task automatic doReset();
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        reset        = 1'b1;
        serial_in    = 1'b0;
        serial_valid = 1'b0;
        data_ready   = 1'b0;
        @(posedge clock);
        #1;
        doReset();
        checkOutput("rst_status", {7'd0, status}, 8'd0);
        checkOutput("rst_valid", {7'd0, data_valid}, 8'd0);
        checkOutput("rst_overrun", {7'd0, overrun}, 8'd0);
        checkOutput("rst_count", frame_count, 8'd0);
        checkOutput("rst_data", data_out, 8'd0);

        // Nominal frame
        data_ready = 1'b1;
        applyStimulus(8'h52, 7, 1'b0);
        checkOutput("nom_status_pre", {7'd0, status}, 8'd0);
        applyStimulus(8'h01, 1, 1'b0);
        checkOutput("nom_status_lock", {7'd0, status}, 8'd1);
        applyStimulus(8'h11, 8, 1'b0);
        checkOutput("nom_v1", {7'd0, data_valid}, 8'd1);
        checkOutput("nom_d1", data_out, 8'h11);
        applyStimulus(8'h22, 8, 1'b0);
        checkOutput("nom_d2", data_out, 8'h22);
        applyStimulus(8'h33, 8, 1'b0);
        checkOutput("nom_d3", data_out, 8'h33);
        applyStimulus(8'h44, 8, 1'b0);
        checkOutput("nom_v4", {7'd0, data_valid}, 8'd1);
        checkOutput("nom_d4", data_out, 8'h44);
        checkOutput("nom_count", frame_count, 8'd1);
        checkOutput("nom_status_end", {7'd0, status}, 8'd0);
        @(posedge clock);
        #1;
        checkOutput("nom_drain", {7'd0, data_valid}, 8'd0);

        // Bit slip, with idle gaps in the payload
        applyStimulus(8'h05, 3, 1'b0);
        applyStimulus(8'h52, 7, 1'b0);
        checkOutput("slip_status_pre", {7'd0, status}, 8'd0);
        applyStimulus(8'h01, 1, 1'b0);
        checkOutput("slip_status_lock", {7'd0, status}, 8'd1);
        applyStimulus(8'hDE, 8, 1'b1);
        checkOutput("slip_d1", data_out, 8'hDE);
        applyStimulus(8'hAD, 8, 1'b1);
        applyStimulus(8'hBE, 8, 1'b1);
        applyStimulus(8'hEF, 8, 1'b1);
        checkOutput("slip_d4", data_out, 8'hEF);
        checkOutput("slip_count", frame_count, 8'd2);
        checkOutput("slip_overrun", {7'd0, overrun}, 8'd0);

        // Backpressure for a whole frame
        data_ready = 1'b0;
        applyStimulus(8'hA5, 8, 1'b0);
        applyStimulus(8'h11, 8, 1'b0);
        checkOutput("bp_v1", {7'd0, data_valid}, 8'd1);
        checkOutput("bp_d1", data_out, 8'h11);
        applyStimulus(8'h22, 8, 1'b0);
        checkOutput("bp_overrun", {7'd0, overrun}, 8'd1);
        applyStimulus(8'h33, 8, 1'b0);
        applyStimulus(8'h44, 8, 1'b0);
        checkOutput("bp_hold", data_out, 8'h11);
        checkOutput("bp_count", frame_count, 8'd3);
        checkOutput("bp_status", {7'd0, status}, 8'd0);
        data_ready = 1'b1;
        @(posedge clock);
        #1;
        checkOutput("bp_release", {7'd0, data_valid}, 8'd0);
        checkOutput("bp_sticky", {7'd0, overrun}, 8'd1);

        // Byte completes on the same edge the previous byte is accepted
        doReset();
        checkOutput("sim_rst_overrun", {7'd0, overrun}, 8'd0);
        data_ready = 1'b0;
        applyStimulus(8'hA5, 8, 1'b0);
        applyStimulus(8'h5A, 8, 1'b0);
        checkOutput("sim_d1", data_out, 8'h5A);
        applyStimulus(8'h1E, 7, 1'b0);
        checkOutput("sim_hold", data_out, 8'h5A);
        data_ready = 1'b1;
        applyStimulus(8'h00, 1, 1'b0);
        checkOutput("sim_valid", {7'd0, data_valid}, 8'd1);
        checkOutput("sim_d2", data_out, 8'h3C);
        checkOutput("sim_overrun", {7'd0, overrun}, 8'd0);
        applyStimulus(8'h77, 8, 1'b0);
        applyStimulus(8'h88, 8, 1'b0);
        checkOutput("sim_d4", data_out, 8'h88);
        checkOutput("sim_count", frame_count, 8'd1);
        checkOutput("sim_overrun_end", {7'd0, overrun}, 8'd0);

        // Reset mid-frame, relock, then counter wrap
        applyStimulus(8'hA5, 8, 1'b0);
        applyStimulus(8'h01, 8, 1'b0);
        applyStimulus(8'h02, 8, 1'b0);
        applyStimulus(8'h00, 3, 1'b0);
        checkOutput("mid_status_pre", {7'd0, status}, 8'd1);
        serial_in    = 1'b1;
        serial_valid = 1'b1;
        doReset();
        serial_valid = 1'b0;
        checkOutput("mid_status", {7'd0, status}, 8'd0);
        checkOutput("mid_valid", {7'd0, data_valid}, 8'd0);
        checkOutput("mid_count", frame_count, 8'd0);
        checkOutput("mid_data", data_out, 8'd0);
        applyStimulus(8'hA5, 8, 1'b0);
        checkOutput("mid_relock", {7'd0, status}, 8'd1);
        applyStimulus(8'h01, 8, 1'b0);
        checkOutput("mid_d1", data_out, 8'h01);
        applyStimulus(8'h02, 8, 1'b0);
        applyStimulus(8'h03, 8, 1'b0);
        applyStimulus(8'h04, 8, 1'b0);
        checkOutput("mid_d4", data_out, 8'h04);
        checkOutput("mid_frame", frame_count, 8'd1);
        for (int f = 0; f < 254; f++) begin
            applyStimulus(8'hA5, 8, 1'b0);
            for (int b = 0; b < 4; b++) begin
                applyStimulus(8'(f + b), 8, 1'b0);
            end
        end
        checkOutput("wrap_255", frame_count, 8'd255);
        applyStimulus(8'hA5, 8, 1'b0);
        for (int b = 0; b < 4; b++) begin
            applyStimulus(8'(8'hC0 + b), 8, 1'b0);
        end
        checkOutput("wrap_0", frame_count, 8'd0);
        checkOutput("wrap_data", data_out, 8'hC3);
        checkOutput("wrap_overrun", {7'd0, overrun}, 8'd0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/frame_deserializer.md
FRAME_DESERIALIZER -- requirements
Module: frame_deserializer

Interface
REQ-001 The block SHALL have parameter SYNC_WORD, default 8'hA5, meaning the 8-bit frame sync pattern, received MSB first.
REQ-002 The block SHALL have parameter PAYLOAD_BYTES, default 4, meaning payload bytes per frame; legal range 1-255.
REQ-003 The block SHALL have port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port serial_in, input, 1 bit: serial data bit from the upstream shift stage.
REQ-006 The block SHALL have port serial_valid, input, 1 bit: serial_in is sampled only on edges where this is 1.
REQ-007 The block SHALL have port data_out, output, 8 bits: assembled payload byte.
REQ-008 The block SHALL have port data_valid, output, 1 bit: data_out holds an unconsumed byte.
REQ-009 The block SHALL have port data_ready, input, 1 bit: downstream accepts the byte on an edge where data_valid and data_ready are both 1.
REQ-010 The block SHALL have port status, output, 1 bit: 1 while locked, i.e. in state PAYLOAD.
REQ-011 The block SHALL have port overrun, output, 1 bit: sticky flag, a completed byte was dropped.
REQ-012 The block SHALL have port frame_count, output, 8 bits: count of completed frames, wrapping.

Function
REQ-013 The block SHALL implement a two-state FSM with states HUNT and PAYLOAD.
REQ-014 In HUNT, each valid bit SHALL shift into an 8-bit window (MSB first: new bit enters LSB).
REQ-015 The HUNT->PAYLOAD transition SHALL occur on the edge where the updated window equals SYNC_WORD; status SHALL be 1 from the following cycle.
REQ-016 Sync detection SHALL be bit-aligned and SHALL allow overlapping matches; there SHALL be no byte alignment in HUNT.
REQ-017 In PAYLOAD, valid bits SHALL assemble bytes MSB first using a 3-bit bit counter and an 8-bit byte counter.
REQ-018 On the edge sampling a byte's 8th bit, the byte SHALL load into the output register if data_valid is 0 or if a handshake occurs on that same edge; data_valid SHALL be 1 from the next cycle (latency 1 cycle after the 8th bit).
REQ-019 Otherwise the byte SHALL be dropped, overrun SHALL be set to 1, and the byte counter SHALL still advance.
REQ-020 A handshake without a new byte SHALL clear data_valid on that edge.
REQ-021 data_out SHALL remain stable while data_valid=1 and data_ready=0.
REQ-022 When the PAYLOAD_BYTES-th byte completes, the FSM SHALL return to HUNT, the window SHALL clear to 0, and frame_count SHALL increment on that same edge, wrapping 255->0.
REQ-023 Edges with serial_valid=0 SHALL change no FSM, window, or counter state; the output handshake SHALL still operate.
REQ-024 overrun SHALL be cleared only by reset.

Reset
REQ-025 With reset=1 at an edge, the block SHALL enter HUNT and set status=0, data_valid=0, data_out=0, overrun=0, frame_count=0, and clear the window and both counters, regardless of state or handshake.
REQ-026 Reset SHALL take priority over all other inputs, including mid-frame; any partial byte SHALL be discarded.

Verification
REQ-027 Reset check: hold reset for 1 edge -> status=0, data_valid=0, overrun=0, frame_count=0 on the next cycle.
REQ-028 Nominal frame: bits 0xA5 then 0x11,0x22,0x33,0x44 with data_ready=1 -> status rises the cycle after the last sync bit; bytes 11,22,33,44 are each valid 1 cycle after their 8th bit; frame_count=1; status returns to 0.
REQ-029 Bit slip: stream 3'b101 then 0xA5 0xDE.. -> lock occurs only after the full 0xA5, and the first byte is 0xDE.
REQ-030 Backpressure: data_ready=0 for a whole 4-byte frame -> data_out=0x11 held; overrun=1; after data_ready=1, one handshake, then data_valid=0.
REQ-031 Simultaneous events: 8th bit of byte 2 arrives on the same edge byte 1 is accepted -> no overrun, data_valid stays 1, data_out=byte 2.
REQ-032 Reset mid-frame after 2 payload bytes plus 3 bits -> HUNT, status=0; the next 0xA5 relocks cleanly; 256 frames -> frame_count wraps to 0.
